// File: rtl/instr_encoder_if.sv
// Request/response bundle between a loader and the instruction encoder.
// The master side issues sessions and requests; the slave side encodes and writes memory.
// Carries the valid/ready request handshake plus the memory-write and status outputs.
interface instr_encoder_if;
    logic        start;
    logic [7:0]  start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [25:0] in_imm;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic [7:0]  err_cnt;
    logic        wrapped;

    modport master (
        output start, start_addr, in_valid, in_mnem, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, err_cnt, wrapped
    );

    modport slave (
        input  start, start_addr, in_valid, in_mnem, in_rs, in_rt, in_rd,
               in_shamt, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata, done, err_cnt, wrapped
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction requests into 32-bit words and writes them to instruction memory.
// Latency: a request accepted at edge k is written (mem_we=1) during the cycle after edge k.
// Backpressure: in_ready is high only while a session is ACTIVE; requests wait otherwise.
module instr_encoder (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        K_R   = 2'd0,
        K_I   = 2'd1,
        K_J   = 2'd2,
        K_INV = 2'd3
    } kind_e;

    state_e      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  maddr_q, maddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  err_q, err_d;
    logic        wrap_q, wrap_d;

    kind_e       kind;
    logic [5:0]  code;
    logic        is_shift;
    logic        is_jr;
    logic [4:0]  rd_f;
    logic [4:0]  shamt_f;
    logic [31:0] enc_word;
    logic        enc_vld;
    logic        accept;

    assign accept = bus.in_valid && (state_q == S_ACTIVE);

    // Classify the mnemonic and pick its funct (R-type) or opcode (I/J-type).
    always_comb begin
        kind     = K_INV;
        code     = 6'h00;
        is_shift = 1'b0;
        is_jr    = 1'b0;
        case (bus.in_mnem)
            5'd0:  begin kind = K_R; code = 6'h20; end
            5'd1:  begin kind = K_R; code = 6'h22; end
            5'd2:  begin kind = K_R; code = 6'h24; end
            5'd3:  begin kind = K_R; code = 6'h25; end
            5'd4:  begin kind = K_R; code = 6'h26; end
            5'd5:  begin kind = K_R; code = 6'h27; end
            5'd6:  begin kind = K_R; code = 6'h2A; end
            5'd7:  begin kind = K_R; code = 6'h00; is_shift = 1'b1; end
            5'd8:  begin kind = K_R; code = 6'h02; is_shift = 1'b1; end
            5'd9:  begin kind = K_R; code = 6'h03; is_shift = 1'b1; end
            5'd10: begin kind = K_R; code = 6'h08; is_jr = 1'b1; end
            5'd11: begin kind = K_I; code = 6'h08; end
            5'd12: begin kind = K_I; code = 6'h0C; end
            5'd13: begin kind = K_I; code = 6'h0D; end
            5'd14: begin kind = K_I; code = 6'h0E; end
            5'd15: begin kind = K_I; code = 6'h23; end
            5'd16: begin kind = K_I; code = 6'h2B; end
            5'd17: begin kind = K_I; code = 6'h04; end
            5'd18: begin kind = K_I; code = 6'h05; end
            5'd19: begin kind = K_J; code = 6'h02; end
            5'd20: begin kind = K_J; code = 6'h03; end
            default: begin kind = K_INV; code = 6'h00; end
        endcase
    end

    // Assemble the instruction word; unused R-type fields are zeroed so the word is canonical.
    always_comb begin
        rd_f     = bus.in_rd;
        shamt_f  = bus.in_shamt;
        enc_word = 32'h0000_0000;
        enc_vld  = 1'b1;
        if (!is_shift) begin
            shamt_f = 5'd0;
        end
        if (is_jr) begin
            rd_f = 5'd0;
        end
        case (kind)
            K_R:     enc_word = {6'b000000, bus.in_rs, bus.in_rt, rd_f, shamt_f, code};
            K_I:     enc_word = {code, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            K_J:     enc_word = {code, bus.in_imm};
            default: enc_vld  = 1'b0;
        endcase
    end

    // Session FSM plus address counter, write staging and error/wrap bookkeeping.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        wrap_d  = wrap_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ACTIVE;
                    addr_d  = bus.start_addr;
                    err_d   = 8'd0;
                    wrap_d  = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (enc_vld) begin
                        we_d    = 1'b1;
                        maddr_d = addr_q;
                        wdata_d = enc_word;
                        addr_d  = addr_q + 8'd1;
                        if (addr_q == 8'hFF) begin
                            wrap_d = 1'b1;
                        end
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (bus.in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any staged write so nothing is written after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 8'd0;
            we_q    <= 1'b0;
            maddr_q <= 8'd0;
            wdata_q <= 32'd0;
            err_q   <= 8'd0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACTIVE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.err_cnt   = err_q;
    assign bus.wrapped   = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised scoreboard bench for instr_encoder with directed boundary sessions.
// Expected writes are computed from the instruction-format rules and queued at acceptance.
// A negedge monitor pops and compares whenever the DUT asserts mem_we or done.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference session state
    int m_addr = 0;
    int m_err  = 0;
    int m_wrap = 0;

    localparam int FUNCT [0:10] = '{32, 34, 36, 37, 38, 39, 42, 0, 2, 3, 8};
    localparam int OPI   [0:7]  = '{8, 12, 13, 14, 35, 43, 4, 5};
    localparam int OPJ   [0:1]  = '{2, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word from field arithmetic; bit 32 = mnemonic is valid.
    function automatic logic [32:0] ref_enc(input int mnem, input int rs, input int rt,
                                            input int rd, input int sh, input logic [25:0] imm);
        longint w;
        w = 0;
        if (mnem <= 10) begin
            w = (longint'(rs) << 21) + (longint'(rt) << 16) + longint'(FUNCT[mnem]);
            if (mnem != 10) w = w + (longint'(rd) << 11);
            if (mnem >= 7 && mnem <= 9) w = w + (longint'(sh) << 6);
            return {1'b1, w[31:0]};
        end else if (mnem <= 18) begin
            w = (longint'(OPI[mnem-11]) << 26) + (longint'(rs) << 21) + (longint'(rt) << 16)
                + longint'(imm[15:0]);
            return {1'b1, w[31:0]};
        end else if (mnem <= 20) begin
            w = (longint'(OPJ[mnem-19]) << 26) + longint'(imm);
            return {1'b1, w[31:0]};
        end
        return 33'd0;
    endfunction

    // Monitor: every mem_we or done cycle must match the oldest expected event.
    always @(negedge clk) begin
        if (reset === 1'b0 && (bus.mem_we === 1'b1 || bus.done === 1'b1)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: mem_we=%0b done=%0b addr=0x%0h with nothing expected at %0t",
                         bus.mem_we, bus.done, bus.mem_addr, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                chk("done", 32'(bus.done), 32'(e.done));
                if (e.we) begin
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("mem_wdata", bus.mem_wdata, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.start_addr = 8'd0;
        bus.in_valid   = 1'b0;
        bus.in_mnem    = 5'd0;
        bus.in_rs      = 5'd0;
        bus.in_rt      = 5'd0;
        bus.in_rd      = 5'd0;
        bus.in_shamt   = 5'd0;
        bus.in_imm     = 26'd0;
        bus.in_last    = 1'b0;
    endtask

    // Called #1 after a rising edge while IDLE; returns #1 after the edge entering ACTIVE.
    task automatic start_session(input int addr);
        bus.start      = 1'b1;
        bus.start_addr = 8'(addr);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        m_addr = addr;
        m_err  = 0;
        m_wrap = 0;
    endtask

    // Presents one request, waits (bounded) for in_ready, records the expected outcome.
    task automatic send(input int mnem, input int rs, input int rt, input int rd,
                        input int sh, input logic [25:0] imm, input bit last);
        int n;
        logic [32:0] r;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_mnem  = 5'(mnem);
        bus.in_rs    = 5'(rs);
        bus.in_rt    = 5'(rt);
        bus.in_rd    = 5'(rd);
        bus.in_shamt = 5'(sh);
        bus.in_imm   = imm;
        bus.in_last  = last;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 1);
        if (bus.in_ready === 1'b1) begin
            r = ref_enc(mnem, rs, rt, rd, sh, imm);
            if (r[32]) begin
                e.we = 1'b1; e.addr = 8'(m_addr); e.data = r[31:0]; e.done = last;
                sb_q.push_back(e);
                m_addr = (m_addr + 1) % 256;
                if (m_addr == 0) m_wrap = 1;
            end else begin
                if (m_err < 255) m_err++;
                if (last) begin
                    e.we = 1'b0; e.addr = 8'd0; e.data = 32'd0; e.done = 1'b1;
                    sb_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Called right after the last send; confirms the scoreboard drained and status holds.
    task automatic end_session();
        @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 0);
        chk("err_cnt", 32'(bus.err_cnt), 32'(m_err));
        chk("wrapped", 32'(bus.wrapped), 32'(m_wrap));
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        chk("err_cnt_hold", 32'(bus.err_cnt), 32'(m_err));
        chk("wrapped_hold", 32'(bus.wrapped), 32'(m_wrap));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
        chk({tag, "_wrapped"}, 32'(bus.wrapped), 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single add, last: write at 0x10 with done
        start_session(8'h10);
        send(0, 1, 2, 3, 0, 26'd0, 1'b1);
        end_session();

        // addi / sll / jal at consecutive addresses
        start_session(8'h30);
        send(11, 0, 5, 0, 0, 26'h0004, 1'b0);
        send(7, 0, 2, 4, 3, 26'd0, 1'b0);
        send(20, 0, 0, 0, 0, 26'h40, 1'b1);
        end_session();

        // Invalid mnemonic between two valid ones
        start_session(8'h50);
        send(0, 7, 8, 9, 0, 26'd0, 1'b0);
        send(25, 1, 1, 1, 1, 26'd1, 1'b0);
        send(1, 3, 4, 5, 0, 26'd0, 1'b1);
        chk("err_cnt_one", 32'(bus.err_cnt), 1);
        end_session();

        // Address wrap 0xFF -> 0x00
        start_session(8'hFF);
        send(2, 1, 2, 3, 0, 26'd0, 1'b0);
        send(17, 4, 5, 0, 0, 26'h3FFFFFF, 1'b1);
        chk("wrapped_set", 32'(bus.wrapped), 1);
        end_session();

        // Reset the cycle after an accept
        start_session(8'h20);
        send(0, 1, 2, 3, 0, 26'd0, 1'b0);
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk_all_zero("midreset");
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("midreset_we_neg", 32'(bus.mem_we), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_in_ready", 32'(bus.in_ready), 0);
            chk("post_reset_mem_we", 32'(bus.mem_we), 0);
        end
        @(posedge clk);
        #1;
        idle_inputs();

        // start held high during ACTIVE must not reload the address
        start_session(8'h40);
        bus.start      = 1'b1;
        bus.start_addr = 8'h80;
        send(3, 1, 1, 1, 0, 26'd0, 1'b0);
        send(9, 0, 6, 7, 31, 26'd0, 1'b0);
        send(10, 31, 0, 5, 5, 26'd0, 1'b1);
        bus.start = 1'b0;
        end_session();

        // in_valid in IDLE is not accepted
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_valid_in_ready", 32'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        // err_cnt saturation
        start_session(8'h00);
        for (int i = 0; i < 257; i++) send(31, 0, 0, 0, 0, 26'd0, 1'b0);
        send(4, 1, 2, 3, 0, 26'd0, 1'b1);
        chk("err_cnt_sat", 32'(bus.err_cnt), 255);
        end_session();

        // Randomised sessions
        for (int s = 0; s < 30; s++) begin
            int len;
            int sa;
            sa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(250, 255)) : int'($urandom_range(0, 255));
            len = $urandom_range(1, 8);
            start_session(sa);
            for (int k = 0; k < len; k++) begin
                int mn;
                mn = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 20)) : int'($urandom_range(21, 31));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(mn, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), 26'($urandom), (k == len - 1));
            end
            end_session();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be as listed in REQ-002..REQ-016.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begins a load session; sampled only in IDLE.
REQ-005 start_addr  in  8  first instruction-memory word address of the session.
REQ-006 in_valid  in  1  an instruction request is present.
REQ-007 in_ready  out  1  the block can accept a request this cycle.
REQ-008 in_mnem  in  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sll, 8 srl, 9 sra, 10 jr, 11 addi, 12 andi, 13 ori, 14 xori, 15 lw, 16 sw, 17 beq, 18 bne, 19 j, 20 jal; codes 21-31 are invalid.
REQ-009 in_rs / in_rt / in_rd / in_shamt  in  5 each  register and shift-amount fields.
REQ-010 in_imm  in  26  bits [15:0] are the I-type immediate; bits [25:0] are the J-type target.
REQ-011 in_last  in  1  marks the final request of the session.
REQ-012 mem_we  out  1  instruction-memory write strobe.
REQ-013 mem_addr / mem_wdata  out  8 / 32  write word address and encoded instruction.
REQ-014 done  out  1  one-cycle pulse at the end of the session.
REQ-015 err_cnt  out  8  count of invalid mnemonics this session; saturates at 255.
REQ-016 wrapped  out  1  sticky flag: the address counter passed 0xFF to 0x00 this session.

Function
REQ-017 The FSM SHALL have three states, IDLE, ACTIVE and DONE: IDLE->ACTIVE on start; ACTIVE->DONE on acceptance of a request with in_last=1; DONE->IDLE unconditionally after one cycle.
REQ-018 in_ready SHALL be 1 only in ACTIVE; a request SHALL be accepted on an edge where in_valid and in_ready are both 1.
REQ-019 On IDLE->ACTIVE, the address counter SHALL load start_addr, and err_cnt and wrapped SHALL clear.
REQ-020 Latency: a request accepted at edge k SHALL drive mem_we=1, with mem_addr and mem_wdata valid, for exactly the cycle after edge k; otherwise mem_we SHALL be 0.
REQ-021 R-type words SHALL be {6'b0, rs, rt, rd, shamt, funct} with funct: add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sll 0x00, srl 0x02, sra 0x03, jr 0x08.
REQ-022 For R-type words, rd and shamt SHALL be forced to 0 for jr, and shamt SHALL be forced to 0 for all non-shift operations.
REQ-023 I-type words SHALL be {op, rs, rt, imm[15:0]} with op: addi 0x08, andi 0x0C, ori 0x0D, xori 0x0E, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
REQ-024 J-type words SHALL be {op, imm[25:0]} with op: j 0x02, jal 0x03.
REQ-025 The address counter SHALL advance by 1 after each write, wrapping 0xFF->0x00 and setting wrapped.
REQ-026 An invalid mnemonic SHALL be accepted but produce no write and no address advance, and SHALL increment err_cnt; if it carries in_last=1, the session SHALL still end.
REQ-027 done SHALL be 1 exactly during the DONE cycle, coincident with the final mem_we if the last request was valid.
REQ-028 start in ACTIVE or DONE SHALL be ignored; in_valid in IDLE or DONE SHALL not be accepted.
REQ-029 err_cnt and wrapped SHALL hold their values after DONE until the next start.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err_cnt=0 and wrapped=0.
REQ-031 Reset mid-session SHALL discard any pending write, and no mem_we SHALL follow reset release without a new start.

Verification
REQ-032 start with start_addr=0x10; add rd=3, rs=1, rt=2 with in_last=1 -> next cycle mem_we=1, addr 0x10, data 0x00221820, done=1.
REQ-033 Session of three requests: addi rt=5, rs=0, imm=0x0004; sll rd=4, rt=2, shamt=3; jal imm=0x40 -> data 0x20050004, 0x000220C0, 0x0C000040 at consecutive addresses.
REQ-034 Invalid mnem 25 between two valid requests -> only 2 writes at consecutive addresses, err_cnt=1.
REQ-035 start_addr=0xFF with two requests -> writes at 0xFF then 0x00, wrapped=1.
REQ-036 Reset asserted the cycle after an accept -> mem_we stays 0 and all outputs are 0; in_valid held after release is not accepted.
REQ-037 start held high during ACTIVE -> no reload of the address counter; in_valid in IDLE -> in_ready=0 and no write.
